// File: rtl/dtc_word_align_ctrl.sv
// Word-alignment controller for a DTC serial link, clocked in the bitclkdiv domain.
// Pulses BITSLIP on the ISERDES until the deserialized word has matched the sync
// pattern for LOCK_CNT consecutive cycles, then holds lock. While locked it watches
// for loss of lock. A separate windowed, saturating counter tallies pattern errors.
//
// Ports:
//   bitclkdiv_i   word clock (rising edge)
//   reset_i       asynchronous active-high reset
//   din_i         deserialized word from the ISERDES
//   align_start_i one-cycle pulse: start or restart alignment
//   errtest_i     one-cycle pulse: start or restart an error-count window
//   bitslip_o     bitslip pulse to the ISERDES
//   locked_o      link aligned
//   align_fail_o  sticky: MAX_SLIP bitslips issued without reaching lock
//   slipcnt_o     bitslips issued in the current attempt
//   errcnt_o      mismatches in the last or current window (saturating)
//   err_busy_o    error window in progress
module dtc_word_align_ctrl #(
  parameter int unsigned    DW           = 16,
  parameter logic [DW-1:0]  SYNC_PATTERN = DW'(16'hBC50),
  parameter int unsigned    LOCK_CNT     = 12,
  parameter int unsigned    SLIP_WAIT    = 8,
  parameter int unsigned    MAX_SLIP     = 250,
  parameter int unsigned    LOSS_THRESH  = 4,
  parameter bit             AUTO_RELOCK  = 1'b1,
  parameter int unsigned    ERR_WIN      = 50000
) (
  input  logic          bitclkdiv_i,
  input  logic          reset_i,
  input  logic [DW-1:0] din_i,
  input  logic          align_start_i,
  input  logic          errtest_i,
  output logic          bitslip_o,
  output logic          locked_o,
  output logic          align_fail_o,
  output logic [7:0]    slipcnt_o,
  output logic [15:0]   errcnt_o,
  output logic          err_busy_o
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WW = $clog2(SLIP_WAIT + 1);
  localparam int unsigned LW = $clog2(LOSS_THRESH + 1);
  localparam int unsigned EW = $clog2(ERR_WIN + 1);

  typedef enum logic [2:0] {
    StIdle, StCheck, StSlip, StWait, StEval, StLocked, StFail
  } state_e;

  state_e          state_q, state_d;
  logic [MW-1:0]   match_q, match_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [LW-1:0]   loss_q, loss_d;
  logic [7:0]      slip_q, slip_d;
  logic            fail_q, fail_d;
  logic            bitslip_q, bitslip_d;
  logic            locked_q, locked_d;
  logic [15:0]     errcnt_q, errcnt_d;
  logic            busy_q, busy_d;
  logic [EW-1:0]   win_q, win_d;

  logic is_sync;
  assign is_sync = (din_i == SYNC_PATTERN);

  // Alignment FSM next state
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    wait_d  = wait_q;
    loss_d  = loss_q;
    slip_d  = slip_q;
    fail_d  = fail_q;
    if (align_start_i) begin
      // Restart overrides every other transition, from any state
      state_d = StCheck;
      match_d = '0;
      wait_d  = '0;
      loss_d  = '0;
      slip_d  = '0;
      fail_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          match_d = '0;
          slip_d  = '0;
          loss_d  = '0;
        end
        StCheck: begin
          if (is_sync) begin
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d = StLocked;
              match_d = '0;
              loss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            state_d = StSlip;
            match_d = '0;
            slip_d  = slip_q + 1'b1;
          end
        end
        StSlip: begin
          state_d = StWait;
          wait_d  = '0;
        end
        StWait: begin
          if (wait_q == WW'(SLIP_WAIT - 1)) begin
            state_d = StEval;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        StEval: begin
          if (slip_q == 8'(MAX_SLIP)) begin
            state_d = StFail;
            fail_d  = 1'b1;
          end else begin
            state_d = StCheck;
            match_d = '0;
          end
        end
        StLocked: begin
          if (is_sync) begin
            loss_d = '0;
          end else if (loss_q == LW'(LOSS_THRESH - 1)) begin
            loss_d  = '0;
            match_d = '0;
            slip_d  = '0;
            state_d = AUTO_RELOCK ? StCheck : StIdle;
          end else begin
            loss_d = loss_q + 1'b1;
          end
        end
        StFail: begin
          fail_d = 1'b1;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Registered outputs: bitslip is high exactly while the FSM sits in SLIP;
  // locked needs one full cycle in LOCKED and drops the moment LOCKED is left.
  always_comb begin
    bitslip_d = (state_d == StSlip);
    locked_d  = (state_q == StLocked) && (state_d == StLocked);
  end

  // Error window, independent of the alignment FSM
  always_comb begin
    errcnt_d = errcnt_q;
    busy_d   = busy_q;
    win_d    = win_q;
    if (errtest_i) begin
      errcnt_d = '0;
      busy_d   = 1'b1;
      win_d    = '0;
    end else if (busy_q) begin
      if (!is_sync && (errcnt_q != 16'hFFFF)) begin
        errcnt_d = errcnt_q + 1'b1;
      end
      if (win_q == EW'(ERR_WIN - 1)) begin
        busy_d = 1'b0;
        win_d  = '0;
      end else begin
        win_d = win_q + 1'b1;
      end
    end
  end

  always_ff @(posedge bitclkdiv_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      match_q   <= '0;
      wait_q    <= '0;
      loss_q    <= '0;
      slip_q    <= '0;
      fail_q    <= 1'b0;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
      errcnt_q  <= '0;
      busy_q    <= 1'b0;
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      wait_q    <= wait_d;
      loss_q    <= loss_d;
      slip_q    <= slip_d;
      fail_q    <= fail_d;
      bitslip_q <= bitslip_d;
      locked_q  <= locked_d;
      errcnt_q  <= errcnt_d;
      busy_q    <= busy_d;
      win_q     <= win_d;
    end
  end

  assign bitslip_o    = bitslip_q;
  assign locked_o     = locked_q;
  assign align_fail_o = fail_q;
  assign slipcnt_o    = slip_q;
  assign errcnt_o     = errcnt_q;
  assign err_busy_o   = busy_q;

endmodule

// File: tb/tb_dtc_word_align_ctrl.sv
// Self-checking bench for dtc_word_align_ctrl. Two instances share the inputs:
// u1 re-aligns automatically on loss of lock, u2 returns to IDLE instead.
// Both use a 100-cycle error window.
module tb_dtc_word_align_ctrl;

  localparam logic [15:0] SYNC = 16'hBC50;
  localparam logic [15:0] BAD  = 16'h1234;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        align_start;
  logic        errtest;

  logic        bs1, lk1, af1, eb1;
  logic [7:0]  sc1;
  logic [15:0] ec1;
  logic        bs2, lk2, af2, eb2;
  logic [7:0]  sc2;
  logic [15:0] ec2;

  dtc_word_align_ctrl #(.AUTO_RELOCK(1'b1), .ERR_WIN(100)) u1 (
    .bitclkdiv_i  (clk),
    .reset_i      (rst),
    .din_i        (din),
    .align_start_i(align_start),
    .errtest_i    (errtest),
    .bitslip_o    (bs1),
    .locked_o     (lk1),
    .align_fail_o (af1),
    .slipcnt_o    (sc1),
    .errcnt_o     (ec1),
    .err_busy_o   (eb1)
  );

  dtc_word_align_ctrl #(.AUTO_RELOCK(1'b0), .ERR_WIN(100)) u2 (
    .bitclkdiv_i  (clk),
    .reset_i      (rst),
    .din_i        (din),
    .align_start_i(align_start),
    .errtest_i    (errtest),
    .bitslip_o    (bs2),
    .locked_o     (lk2),
    .align_fail_o (af2),
    .slipcnt_o    (sc2),
    .errcnt_o     (ec2),
    .err_busy_o   (eb2)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  bit   model_en = 1'b0;
  int   rot = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   pulses2 = 0;
  int   last_pulse = -100;
  logic prev_bs = 1'b0;

  typedef struct {
    int rot;
    int exp_slips;
    int exp_lat;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
    return r;
  endfunction

  // One clock: sample 1 time unit after the edge, track bitslip pulses, and let the
  // ISERDES model undo one bit of rotation per bitslip pulse.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bs2) pulses2++;
    if (bs1) begin
      pulses++;
      chk("bitslip_width", {31'd0, prev_bs}, 32'd0);
      if (last_pulse >= 0) chk("bitslip_gap", (cyc - last_pulse >= 10) ? 1 : 0, 1);
      last_pulse = cyc;
      if (model_en && rot > 0) rot--;
    end
    prev_bs = bs1;
    if (model_en) din = rotl(SYNC, rot);
  endtask

  task automatic pulse_start();
    align_start = 1'b1;
    step();
    align_start = 1'b0;
  endtask

  task automatic clear_pulses();
    pulses     = 0;
    pulses2    = 0;
    last_pulse = -100;
  endtask

  initial begin
    int n;
    tbl[0] = '{rot: 0, exp_slips: 0, exp_lat: 13};
    tbl[1] = '{rot: 1, exp_slips: 1, exp_lat: 24};
    tbl[2] = '{rot: 3, exp_slips: 3, exp_lat: 46};
    tbl[3] = '{rot: 5, exp_slips: 5, exp_lat: 68};

    rst = 1'b1;
    din = SYNC;
    align_start = 1'b0;
    errtest = 1'b0;
    #3;
    chk("rst_bitslip", {31'd0, bs1}, 0);
    chk("rst_locked", {31'd0, lk1}, 0);
    chk("rst_fail", {31'd0, af1}, 0);
    chk("rst_slipcnt", {24'd0, sc1}, 0);
    chk("rst_errcnt", {16'd0, ec1}, 0);
    chk("rst_busy", {31'd0, eb1}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle without align_start: nothing happens even on a bad stream
    din = BAD;
    clear_pulses();
    for (int i = 0; i < 15; i++) step();
    chk("idle_no_slip", pulses, 0);
    chk("idle_locked", {31'd0, lk1}, 0);

    // Alignment from several initial rotations
    for (int i = 0; i < 4; i++) begin
      rot = tbl[i].rot;
      model_en = 1'b1;
      din = rotl(SYNC, rot);
      clear_pulses();
      pulse_start();
      n = 0;
      while (!lk1 && n < 200) begin
        step();
        n++;
      end
      chk($sformatf("lock_latency_rot%0d", tbl[i].rot), n, tbl[i].exp_lat);
      chk($sformatf("locked_rot%0d", tbl[i].rot), {31'd0, lk1}, 1);
      chk($sformatf("slipcnt_rot%0d", tbl[i].rot), {24'd0, sc1}, tbl[i].exp_slips);
      chk($sformatf("pulses_rot%0d", tbl[i].rot), pulses, tbl[i].exp_slips);
    end
    model_en = 1'b0;

    // Never aligned: MAX_SLIP pulses, then sticky failure
    din = BAD;
    clear_pulses();
    pulse_start();
    n = 0;
    while (!af1 && n < 4000) begin
      step();
      n++;
    end
    chk("fail_flag", {31'd0, af1}, 1);
    chk("fail_pulses", pulses, 250);
    chk("fail_slipcnt", {24'd0, sc1}, 250);
    chk("fail_locked", {31'd0, lk1}, 0);
    for (int i = 0; i < 20; i++) step();
    chk("fail_sticky", {31'd0, af1}, 1);
    chk("fail_no_more_slips", pulses, 250);
    chk("fail_slipcnt_hold", {24'd0, sc1}, 250);
    din = SYNC;
    pulse_start();
    chk("restart_clears_fail", {31'd0, af1}, 0);
    chk("restart_clears_slipcnt", {24'd0, sc1}, 0);

    // Loss of lock on both instances
    n = 0;
    while (!(lk1 && lk2) && n < 50) begin
      step();
      n++;
    end
    chk("loss_pre_lock1", {31'd0, lk1}, 1);
    chk("loss_pre_lock2", {31'd0, lk2}, 1);
    din = BAD;
    for (int i = 0; i < 3; i++) step();
    chk("three_bad_lock1", {31'd0, lk1}, 1);
    din = SYNC;
    step();
    chk("good_clears_loss", {31'd0, lk1}, 1);
    din = BAD;
    for (int i = 0; i < 3; i++) step();
    chk("three_bad_again", {31'd0, lk1}, 1);
    chk("three_bad_again2", {31'd0, lk2}, 1);
    clear_pulses();
    step();
    chk("four_bad_unlock1", {31'd0, lk1}, 0);
    chk("four_bad_unlock2", {31'd0, lk2}, 0);
    for (int i = 0; i < 30; i++) step();
    chk("relock_pulses", pulses, 3);
    chk("relock_slipcnt", {24'd0, sc1}, 3);
    chk("noauto_no_slip", pulses2, 0);
    chk("noauto_slipcnt", {24'd0, sc2}, 0);
    chk("noauto_locked", {31'd0, lk2}, 0);

    // Error window with 7 bad words (cycles 14, 28, ..., 98)
    din = SYNC;
    errtest = 1'b1;
    step();
    errtest = 1'b0;
    chk("win_busy_start", {31'd0, eb1}, 1);
    chk("win_errcnt_start", {16'd0, ec1}, 0);
    for (int i = 1; i <= 100; i++) begin
      din = (i % 14 == 0) ? BAD : SYNC;
      step();
      if (i == 50) chk("win_errcnt_mid", {16'd0, ec1}, 3);
      if (i == 99) chk("win_busy_last", {31'd0, eb1}, 1);
    end
    chk("win_busy_end", {31'd0, eb1}, 0);
    chk("win_errcnt_end", {16'd0, ec1}, 7);
    din = BAD;
    for (int i = 0; i < 5; i++) step();
    chk("win_errcnt_hold", {16'd0, ec1}, 7);

    // Restart mid-window
    errtest = 1'b1;
    step();
    errtest = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("rewin_count20", {16'd0, ec1}, 20);
    errtest = 1'b1;
    step();
    errtest = 1'b0;
    chk("rewin_cleared", {16'd0, ec1}, 0);
    chk("rewin_busy", {31'd0, eb1}, 1);
    for (int i = 1; i <= 100; i++) begin
      din = (i == 1 || i == 100) ? BAD : SYNC;
      step();
      if (i == 99) chk("rewin_busy_last", {31'd0, eb1}, 1);
    end
    chk("rewin_busy_end", {31'd0, eb1}, 0);
    chk("rewin_errcnt", {16'd0, ec1}, 2);

    // align_start and errtest together
    din = SYNC;
    align_start = 1'b1;
    errtest = 1'b1;
    step();
    align_start = 1'b0;
    errtest = 1'b0;
    chk("both_busy", {31'd0, eb1}, 1);
    chk("both_unlocked", {31'd0, lk1}, 0);
    for (int i = 0; i < 13; i++) step();
    chk("both_locked", {31'd0, lk1}, 1);
    chk("both_errcnt", {16'd0, ec1}, 0);

    // Asynchronous reset in WAIT with slipcnt and errcnt nonzero
    din = BAD;
    align_start = 1'b1;
    errtest = 1'b1;
    step();
    align_start = 1'b0;
    errtest = 1'b0;
    step();
    chk("pre_rst_bitslip", {31'd0, bs1}, 1);
    step();
    step();
    chk("pre_rst_slipcnt", {24'd0, sc1}, 1);
    chk("pre_rst_errcnt", {16'd0, ec1}, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_bitslip", {31'd0, bs1}, 0);
    chk("arst_locked", {31'd0, lk1}, 0);
    chk("arst_fail", {31'd0, af1}, 0);
    chk("arst_slipcnt", {24'd0, sc1}, 0);
    chk("arst_errcnt", {16'd0, ec1}, 0);
    chk("arst_busy", {31'd0, eb1}, 0);
    #1;
    rst = 1'b0;
    clear_pulses();
    for (int i = 0; i < 20; i++) step();
    chk("post_rst_idle_slips", pulses, 0);
    chk("post_rst_slipcnt", {24'd0, sc1}, 0);
    chk("post_rst_busy", {31'd0, eb1}, 0);
    chk("post_rst_errcnt", {16'd0, ec1}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog timeout");
  end

endmodule

// File: doc/dtc_word_align_ctrl.md
Name: dtc_word_align_ctrl

Overview:
- Parametrised word-alignment controller for DTC serial links on the SRU.
- Sits between an external ISERDES deserializer and the DTC receive logic, in the bitclkdiv domain.
- Drives BITSLIP until the deserialized word matches a configurable sync pattern for N consecutive cycles, then holds lock.
- Monitors lock, detects loss of lock and optionally re-aligns automatically. Includes a windowed, saturating pattern-error counter.

Parameters:
DW, 16, deserialized word width
SYNC_PATTERN, 16'hBC50, idle/sync word expected on an aligned link (DW bits)
LOCK_CNT, 12, consecutive matching words required to declare lock (>=1)
SLIP_WAIT, 8, settle cycles after each bitslip pulse (>=2, covers the ISERDES 2-cycle bitslip latency)
MAX_SLIP, 250, bitslip attempts before declaring failure (1..255)
LOSS_THRESH, 4, consecutive mismatches while locked that count as loss of lock (>=1)
AUTO_RELOCK, 1, 1 = re-align automatically on loss of lock; 0 = return to IDLE
ERR_WIN, 50000, error-test window length in cycles

Ports:
bitclkdiv  in  1  word clock; all logic on the rising edge
reset  in  1  asynchronous active-high reset
din  in  DW  deserialized word from the ISERDES
align_start  in  1  one-cycle pulse that starts or restarts alignment
errtest  in  1  one-cycle pulse that starts an error-count window
bitslip  out  1  bitslip pulse to the ISERDES
locked  out  1  link aligned
align_fail  out  1  sticky flag: MAX_SLIP attempts made without lock
slipcnt  out  8  bitslips issued in the current attempt
errcnt  out  16  mismatches in the last or current window (saturating)
err_busy  out  1  error window in progress

Behaviour:
- Reset (asynchronous, immediate): every output is 0, FSM goes to IDLE, all internal counters are 0. Reset mid-operation aborts everything, including an open error window.
- All outputs are registered.
- FSM states are IDLE, CHECK, SLIP, WAIT, EVAL, LOCKED, FAIL:
  - IDLE: bitslip=0, match/slip counters cleared. On align_start, go to CHECK.
  - CHECK: if din==SYNC_PATTERN, matchcnt++. When this is the LOCK_CNT-th consecutive match, go to LOCKED; locked=1 the following cycle. On a mismatch, clear matchcnt and go to SLIP.
  - SLIP: bitslip=1 for exactly this one cycle, slipcnt++, then go to WAIT.
  - WAIT: bitslip=0. Stay SLIP_WAIT cycles, then go to EVAL.
  - EVAL: if slipcnt==MAX_SLIP, go to FAIL; otherwise go to CHECK with matchcnt=0.
  - LOCKED: locked=1. Count consecutive mismatches (losscnt); any match clears it. When losscnt reaches LOSS_THRESH, locked drops the next cycle; with AUTO_RELOCK=1 go to CHECK (slipcnt cleared), otherwise go to IDLE.
  - FAIL: align_fail=1, locked=0. The flag stays set until the next align_start.
- align_start in any state other than IDLE clears slipcnt, matchcnt, losscnt and align_fail, drops locked, and goes to CHECK. It takes priority over every other transition in that cycle.
- bitslip is never high on two consecutive cycles. Minimum spacing between pulses is SLIP_WAIT+2 cycles.
- slipcnt holds its value in LOCKED and FAIL, so the slip position stays readable.
- Error window (independent of the FSM):
  - On errtest: errcnt=0, err_busy=1, window counter=0.
  - During the window, each cycle with din!=SYNC_PATTERN increments errcnt, saturating at 16'hFFFF.
  - The window closes after exactly ERR_WIN sampled cycles; err_busy drops and errcnt holds.
  - errtest during an open window restarts the window and clears errcnt.
  - align_start and errtest in the same cycle are both honoured.

Test Plan:
- Aligned stream: din=16'hBC50 constantly, align_start pulse → no bitslip; locked rises 13 cycles after the pulse (1 entry cycle + 12 matches); slipcnt=0.
- Misaligned by 3: the bench model rotates din by one bit per bitslip and becomes aligned after 3 slips → exactly 3 bitslip pulses, each 1 cycle wide and ≥10 cycles apart; then locked=1, slipcnt=3.
- Never aligned: din=16'h1234 → 250 bitslip pulses, then align_fail=1, locked=0, slipcnt=250. A later align_start clears align_fail and slipcnt.
- Loss of lock: once locked, inject 3 bad words → locked stays 1; inject 4 consecutive bad words → locked=0 and re-alignment starts (AUTO_RELOCK=1). Repeat with AUTO_RELOCK=0 → FSM returns to IDLE with no bitslip.
- Error window: ERR_WIN=100, 7 bad words inside the window → err_busy high for 100 cycles, then errcnt=7. A second errtest mid-window resets errcnt to 0 and restarts the window.
- Asynchronous reset asserted mid-WAIT with bitslip/locked/errcnt nonzero → all outputs 0 without a clock edge; after release, the FSM stays in IDLE until align_start.
